// File: rtl/countdown_dispatcher.sv
// countdown_dispatcher: emits batch indices N-1..0 on a valid/ready stream (auto-reload via COUNTDOWN_DISPATCH_AUTO_RELOAD_EN)
module countdown_dispatcher #(
  parameter int BITS = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ld,
  input  logic [BITS-1:0] data_in,
  input  logic            abort,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] out_idx,
  output logic [BITS-1:0] remaining,
  output logic            busy,
  output logic            done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [BITS-1:0] idx_n, rem_n;
  logic zero_ld, zero_ld_n;
`ifdef COUNTDOWN_DISPATCH_AUTO_RELOAD_EN
  logic [BITS-1:0] reload;
  // keep the last nonzero batch size so DONE can restart it
  always_ff @(posedge clk)
    if (reset) reload <= '0;
    else if (state == IDLE && ld && data_in != '0) reload <= data_in;
`endif
  assign out_valid = state == RUN;
  assign busy      = state != IDLE;
  assign done      = state == DONE;
  // state, index and count registers
  always_ff @(posedge clk)
    if (reset) begin
      state     <= IDLE;
      out_idx   <= '0;
      remaining <= '0;
      zero_ld   <= 1'b0;
    end else begin
      state     <= state_n;
      out_idx   <= idx_n;
      remaining <= rem_n;
      zero_ld   <= zero_ld_n;
    end
  // next-state and counter update; idx always tracks remaining-1 while running
  always_comb begin
    state_n   = state;
    idx_n     = out_idx;
    rem_n     = remaining;
    zero_ld_n = zero_ld;
    case (state)
      IDLE: if (ld) begin
        state_n   = data_in == '0 ? DONE : RUN;
        rem_n     = data_in;
        idx_n     = data_in == '0 ? '0 : data_in - 1'b1;
        zero_ld_n = data_in == '0;
      end
      RUN: if (abort) begin
        state_n = IDLE;
        rem_n   = '0;
        idx_n   = '0;
      end else if (out_ready) begin
        state_n = remaining == 1 ? DONE : RUN;
        rem_n   = remaining - 1'b1;
        idx_n   = remaining == 1 ? '0 : out_idx - 1'b1;
      end
      DONE: begin
`ifdef COUNTDOWN_DISPATCH_AUTO_RELOAD_EN
        state_n = zero_ld ? IDLE : RUN;
        rem_n   = zero_ld ? '0 : reload;
        idx_n   = zero_ld ? '0 : reload - 1'b1;
`else
        state_n = IDLE;
`endif
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_countdown_dispatcher.sv
// tb_countdown_dispatcher: scoreboard bench for countdown_dispatcher
module tb_countdown_dispatcher;
  localparam int BITS = 8;
  logic clk = 0, reset = 1, ld = 0, abort = 0, out_ready = 0;
  logic [BITS-1:0] data_in = '0;
  logic out_valid, busy, done;
  logic [BITS-1:0] out_idx, remaining;
  int checks = 0, failures = 0;
  int q[$];

  countdown_dispatcher #(.BITS(BITS)) dut (
    .clk(clk), .reset(reset), .ld(ld), .data_in(data_in), .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .remaining(remaining), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor: -1 in the queue stands for a done pulse
  always @(negedge clk) if (!reset) begin
    if (done) begin
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else chk("done_order", -1, q.pop_front());
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_beat", int'(out_idx), -2);
      else begin
        int e;
        e = q.pop_front();
        chk("beat_idx", int'(out_idx), e);
        chk("beat_remaining", int'(remaining), e + 1);
      end
    end
  end

  task automatic cyc(input logic l, input int d, input logic ab, input logic r);
    @(posedge clk);
    #1;
    ld = l; data_in = BITS'(d); abort = ab; out_ready = r;
  endtask

  task automatic drain(input int n);
    int k = 0;
    while (q.size() != 0 && k < n) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("drain_timeout", q.size(), 0);
  endtask

  task automatic idle_zero(input string name);
    chk({name, "_valid"}, int'(out_valid), 0);
    chk({name, "_idx"}, int'(out_idx), 0);
    chk({name, "_rem"}, int'(remaining), 0);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_done"}, int'(done), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 0;
    idle_zero("reset");
    // batch of 4, ready high
    q = '{3, 2, 1, 0, -1};
    cyc(1, 4, 0, 1);
    cyc(0, 0, 0, 1);
    chk("t1_busy_run", int'(busy), 1);
    drain(10);
    chk("t1_busy_after", int'(busy), 0);
    chk("t1_rem_after", int'(remaining), 0);
    // batch of 3 with stalls
    q = '{2, 1, 0, -1};
    cyc(1, 3, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    chk("t2_stall_idx", int'(out_idx), 1);
    chk("t2_stall_rem", int'(remaining), 2);
    chk("t2_stall_valid", int'(out_valid), 1);
    cyc(0, 0, 0, 0);
    chk("t2_stall2_idx", int'(out_idx), 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    chk("t2_stall3_idx", int'(out_idx), 0);
    cyc(0, 0, 0, 1);
    drain(10);
    chk("t2_busy_after", int'(busy), 0);
    // zero-size load
    q = '{-1};
    cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("t3_valid", int'(out_valid), 0);
    chk("t3_done", int'(done), 1);
    drain(5);
    idle_zero("t3_idle");
    // abort after two handshakes
    q = '{7, 6};
    cyc(1, 8, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 0);
    chk("t4_rem_pre", int'(remaining), 6);
    cyc(0, 0, 0, 0);
    idle_zero("t4_abort");
    chk("t4_q", q.size(), 0);
    cyc(0, 0, 0, 0);
    idle_zero("t4_nodone");
    q = '{1, 0, -1};
    cyc(1, 2, 0, 1);
    cyc(0, 0, 0, 1);
    drain(8);
    // second ld mid-run is ignored, then reset mid-batch
    q = '{4, 3};
    cyc(1, 5, 0, 1);
    cyc(1, 5, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    chk("t5_idx_mid", int'(out_idx), 2);
    chk("t5_rem_mid", int'(remaining), 3);
    reset = 1;
    cyc(0, 0, 0, 0);
    reset = 0;
    idle_zero("t5_reset");
    chk("t5_q", q.size(), 0);
`ifdef COUNTDOWN_DISPATCH_AUTO_RELOAD_EN
    q = '{1, 0, -1, 1, 0, -1, 1};
    cyc(1, 2, 0, 1);
    repeat (6) cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 0);
    idle_zero("t6_abort");
    chk("t6_q", q.size(), 0);
`endif
    repeat (2) cyc(0, 0, 0, 0);
    chk("final_q", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
